// File: rtl/hazard_if.sv
// Bundle between the pipeline control path and hazard_unit: stage instructions,
// branch/memory status in, stall/flush controls and the stall counter out.
interface hazard_if #(
  parameter int XLEN = 32,
  parameter int CNTW = 32
);
  logic            taken_branch;
  logic            mem_busy;
  logic [XLEN-1:0] if_id_instr;
  logic [XLEN-1:0] id_ex_instr;
  logic [XLEN-1:0] ex_mem_instr;
  logic [XLEN-1:0] mem_wb_instr;
  logic            stall_if;
  logic            stall_id;
  logic            stall_ex;
  logic            stall_mem;
  logic            flush_id;
  logic            flush_ex;
  logic [CNTW-1:0] stall_cycles;

  modport master (
    output taken_branch, mem_busy, if_id_instr, id_ex_instr, ex_mem_instr, mem_wb_instr,
    input  stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, stall_cycles
  );

  modport slave (
    input  taken_branch, mem_busy, if_id_instr, id_ex_instr, ex_mem_instr, mem_wb_instr,
    output stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, stall_cycles
  );
endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: load-use bubbles, branch flush, memory freeze, stall counter.
// Define HAZARD_FWD_EN when forwarding exists; otherwise every RAW match also stalls.
module hazard_unit #(
  parameter int XLEN     = 32,
  parameter int LOAD_LAT = 1,
  parameter int CNTW     = 32
) (
  input logic     clk,
  input logic     rst,
  hazard_if.slave hz
);
  localparam int CW = $clog2(LOAD_LAT + 1);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic {RUN, LU_STALL} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CNTW-1:0] stall_cycles_q, stall_cycles_d;
  logic            load_use;
  logic            raw_stall;
  logic            stall_front;
  logic            stall_back;
  logic            flush_id_o;
  logic            flush_ex_o;

  function automatic logic reads_rs1(input logic [XLEN-1:0] instr);
    case (instr[6:0])
      OPC_OP, OPC_OPIMM, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JALR: reads_rs1 = 1'b1;
      default:                                                      reads_rs1 = 1'b0;
    endcase
  endfunction

  function automatic logic reads_rs2(input logic [XLEN-1:0] instr);
    case (instr[6:0])
      OPC_OP, OPC_STORE, OPC_BRANCH: reads_rs2 = 1'b1;
      default:                       reads_rs2 = 1'b0;
    endcase
  endfunction

  function automatic logic writes_rd(input logic [XLEN-1:0] instr);
    case (instr[6:0])
      OPC_OP, OPC_OPIMM, OPC_LOAD, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR: writes_rd = 1'b1;
      default:                                                            writes_rd = 1'b0;
    endcase
  endfunction

  // x0 never matches, and register fields an opcode does not use are ignored
  function automatic logic raw_match(input logic [XLEN-1:0] cons, input logic [XLEN-1:0] prod);
    logic [4:0] rd;
    rd = prod[11:7];
    raw_match = writes_rd(prod) && (rd != 5'd0) &&
                ((reads_rs1(cons) && (cons[19:15] == rd)) ||
                 (reads_rs2(cons) && (cons[24:20] == rd)));
  endfunction

  always_comb begin
    load_use = (hz.id_ex_instr[6:0] == OPC_LOAD) && raw_match(hz.if_id_instr, hz.id_ex_instr);
  end

`ifdef HAZARD_FWD_EN
  assign raw_stall = 1'b0;
`else
  assign raw_stall = raw_match(hz.if_id_instr, hz.id_ex_instr) |
                     raw_match(hz.if_id_instr, hz.ex_mem_instr) |
                     raw_match(hz.if_id_instr, hz.mem_wb_instr);
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= RUN;
      cnt_q          <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  // The hazard cycle itself is the first bubble, so LU_STALL covers LOAD_LAT-1 more
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (hz.mem_busy) begin
      state_d = state_q;
      cnt_d   = cnt_q;
    end else if (hz.taken_branch) begin
      state_d = RUN;
      cnt_d   = '0;
    end else if (state_q == LU_STALL) begin
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) state_d = RUN;
    end else if (load_use && (LOAD_LAT > 1)) begin
      state_d = LU_STALL;
      cnt_d   = CW'(LOAD_LAT - 1);
    end
  end

  always_comb begin
    stall_front = 1'b0;
    stall_back  = 1'b0;
    flush_id_o  = 1'b0;
    flush_ex_o  = 1'b0;
    if (!rst) begin
      stall_front = 1'b0;
    end else if (hz.mem_busy) begin
      stall_front = 1'b1;
      stall_back  = 1'b1;
    end else if (hz.taken_branch) begin
      flush_id_o = 1'b1;
      flush_ex_o = 1'b1;
    end else if ((state_q == LU_STALL) || load_use || raw_stall) begin
      stall_front = 1'b1;
      flush_ex_o  = 1'b1;
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall_front && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + CNTW'(1);
  end

  assign hz.stall_if     = stall_front;
  assign hz.stall_id     = stall_front;
  assign hz.stall_ex     = stall_back;
  assign hz.stall_mem    = stall_back;
  assign hz.flush_id     = flush_id_o;
  assign hz.flush_ex     = flush_ex_o;
  assign hz.stall_cycles = stall_cycles_q;
endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: LOAD_LAT=1, LOAD_LAT=3 and a 3-bit-counter instance share stimulus.
// Expected RAW behaviour follows HAZARD_FWD_EN the same way the design does.
module tb_hazard_unit;
  localparam logic [31:0] NOP      = 32'h00000013;
  localparam logic [31:0] LW_X5    = 32'h00002283;
  localparam logic [31:0] LW_X0    = 32'h00002003;
  localparam logic [31:0] ADD_X5X7 = 32'h00728333;
  localparam logic [31:0] ADD_X0X1 = 32'h00100333;
  localparam logic [31:0] LUI_X7   = 32'h000283B7;
  localparam logic [31:0] SW_X5    = 32'h0050A023;
  localparam logic [31:0] ADD_X3   = 32'h002081B3;
  localparam logic [31:0] SUB_X3X1 = 32'h40118233;

  // {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex}
  localparam logic [5:0] NONE  = 6'b000000;
  localparam logic [5:0] STALL = 6'b110001;
  localparam logic [5:0] BUSY  = 6'b111100;
  localparam logic [5:0] BR    = 6'b000011;
`ifdef HAZARD_FWD_EN
  localparam logic [5:0] RAW_EXP = NONE;
`else
  localparam logic [5:0] RAW_EXP = STALL;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        taken_branch, mem_busy;
  logic [31:0] if_id, id_ex, ex_mem, mem_wb;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  hazard_if #(.XLEN(32), .CNTW(32)) bus1 ();
  hazard_if #(.XLEN(32), .CNTW(32)) bus3 ();
  hazard_if #(.XLEN(32), .CNTW(3))  buss ();

  hazard_unit #(.XLEN(32), .LOAD_LAT(1), .CNTW(32)) dut1 (.clk(clk), .rst(rst), .hz(bus1));
  hazard_unit #(.XLEN(32), .LOAD_LAT(3), .CNTW(32)) dut3 (.clk(clk), .rst(rst), .hz(bus3));
  hazard_unit #(.XLEN(32), .LOAD_LAT(1), .CNTW(3))  duts (.clk(clk), .rst(rst), .hz(buss));

  assign bus1.taken_branch = taken_branch;
  assign bus1.mem_busy     = mem_busy;
  assign bus1.if_id_instr  = if_id;
  assign bus1.id_ex_instr  = id_ex;
  assign bus1.ex_mem_instr = ex_mem;
  assign bus1.mem_wb_instr = mem_wb;
  assign bus3.taken_branch = taken_branch;
  assign bus3.mem_busy     = mem_busy;
  assign bus3.if_id_instr  = if_id;
  assign bus3.id_ex_instr  = id_ex;
  assign bus3.ex_mem_instr = ex_mem;
  assign bus3.mem_wb_instr = mem_wb;
  assign buss.taken_branch = taken_branch;
  assign buss.mem_busy     = mem_busy;
  assign buss.if_id_instr  = if_id;
  assign buss.id_ex_instr  = id_ex;
  assign buss.ex_mem_instr = ex_mem;
  assign buss.mem_wb_instr = mem_wb;

  logic [5:0] out1, out3;
  assign out1 = {bus1.stall_if, bus1.stall_id, bus1.stall_ex, bus1.stall_mem, bus1.flush_id, bus1.flush_ex};
  assign out3 = {bus3.stall_if, bus3.stall_id, bus3.stall_ex, bus3.stall_mem, bus3.flush_id, bus3.flush_ex};

  task automatic applyStimulus(input logic r, input logic br, input logic mb, input logic [31:0] i_ifid,
                               input logic [31:0] i_idex, input logic [31:0] i_exmem, input logic [31:0] i_memwb);
    rst          = r;
    taken_branch = br;
    mem_busy     = mb;
    if_id        = i_ifid;
    id_ex        = i_idex;
    ex_mem       = i_exmem;
    mem_wb       = i_memwb;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] bench did not finish");
  end

  initial begin
    // reset holds every output low even with branch and memory stall requested
    applyStimulus(1'b0, 1'b1, 1'b1, ADD_X5X7, LW_X5, NOP, NOP);
    checkOutput("reset_out1", 32'(out1), 32'(NONE));
    checkOutput("reset_out3", 32'(out3), 32'(NONE));
    tick();
    tick();
    checkOutput("reset_cnt1", bus1.stall_cycles, 32'd0);

    applyStimulus(1'b1, 1'b0, 1'b0, NOP, NOP, NOP, NOP);
    checkOutput("idle_out1", 32'(out1), 32'(NONE));
    checkOutput("idle_out3", 32'(out3), 32'(NONE));
    tick();

    // load-use with one and three bubbles
    applyStimulus(1'b1, 1'b0, 1'b0, ADD_X5X7, LW_X5, NOP, NOP);
    checkOutput("lu_hit_out1", 32'(out1), 32'(STALL));
    checkOutput("lu_hit_out3", 32'(out3), 32'(STALL));
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, NOP, NOP, NOP, NOP);
    checkOutput("lu_after_out1", 32'(out1), 32'(NONE));
    checkOutput("lu_cnt1", bus1.stall_cycles, 32'd1);
    checkOutput("lu_bubble2_out3", 32'(out3), 32'(STALL));
    tick();
    checkOutput("lu_bubble3_out3", 32'(out3), 32'(STALL));
    tick();
    checkOutput("lu_done_out3", 32'(out3), 32'(NONE));
    checkOutput("lu_cnt3", bus3.stall_cycles, 32'd3);
    tick();

    // x0 and unused register fields never hazard; store rs2 does
    applyStimulus(1'b1, 1'b0, 1'b0, ADD_X0X1, LW_X0, NOP, NOP);
    checkOutput("x0_out1", 32'(out1), 32'(NONE));
    checkOutput("x0_out3", 32'(out3), 32'(NONE));
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, LUI_X7, LW_X5, NOP, NOP);
    checkOutput("unused_rs_out3", 32'(out3), 32'(NONE));
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, SW_X5, LW_X5, NOP, NOP);
    checkOutput("store_rs2_out3", 32'(out3), 32'(STALL));
    tick();

    // branch in the second bubble cancels the rest of the stall
    applyStimulus(1'b1, 1'b1, 1'b0, NOP, NOP, NOP, NOP);
    checkOutput("br_in_stall_out3", 32'(out3), 32'(BR));
    checkOutput("br_out1", 32'(out1), 32'(BR));
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, NOP, NOP, NOP, NOP);
    checkOutput("br_after_out3", 32'(out3), 32'(NONE));
    checkOutput("br_cnt3", bus3.stall_cycles, 32'd4);
    tick();

    // memory freeze while the counter sits at 1
    applyStimulus(1'b1, 1'b0, 1'b0, ADD_X5X7, LW_X5, NOP, NOP);
    checkOutput("mb_hit_out3", 32'(out3), 32'(STALL));
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, NOP, NOP, NOP, NOP);
    checkOutput("mb_bubble2_out3", 32'(out3), 32'(STALL));
    tick();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, NOP, NOP, NOP, NOP);
      checkOutput("mb_freeze_out3", 32'(out3), 32'(BUSY));
      tick();
    end
    applyStimulus(1'b1, 1'b0, 1'b0, NOP, NOP, NOP, NOP);
    checkOutput("mb_last_bubble_out3", 32'(out3), 32'(STALL));
    tick();
    checkOutput("mb_done_out3", 32'(out3), 32'(NONE));
    checkOutput("mb_cnt3", bus3.stall_cycles, 32'd11);

    // branch held under mem_busy acts once memory is ready
    applyStimulus(1'b1, 1'b1, 1'b1, NOP, NOP, NOP, NOP);
    checkOutput("br_mb_out3", 32'(out3), 32'(BUSY));
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, NOP, NOP, NOP, NOP);
    checkOutput("br_released_out3", 32'(out3), 32'(BR));
    tick();

    // reset in the middle of a stall
    applyStimulus(1'b1, 1'b0, 1'b0, ADD_X5X7, LW_X5, NOP, NOP);
    checkOutput("rst_hit_out3", 32'(out3), 32'(STALL));
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, NOP, NOP, NOP, NOP);
    checkOutput("rst_mid_out3", 32'(out3), 32'(NONE));
    tick();
    checkOutput("rst_mid_cnt3", bus3.stall_cycles, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, NOP, NOP, NOP, NOP);
    checkOutput("rst_abort_out3", 32'(out3), 32'(NONE));
    tick();

    // 3-bit counter saturates at 7
    applyStimulus(1'b1, 1'b0, 1'b1, NOP, NOP, NOP, NOP);
    for (int i = 0; i < 7; i++) tick();
    checkOutput("sat_reach", 32'(buss.stall_cycles), 32'd7);
    tick();
    tick();
    checkOutput("sat_hold", 32'(buss.stall_cycles), 32'd7);

    // RAW on older stages depends on forwarding
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, SUB_X3X1, NOP, ADD_X3, NOP);
      checkOutput("raw_exmem_out1", 32'(out1), 32'(RAW_EXP));
      tick();
    end
    applyStimulus(1'b1, 1'b0, 1'b0, SUB_X3X1, NOP, NOP, NOP);
    checkOutput("raw_clear_out1", 32'(out1), 32'(NONE));
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, SUB_X3X1, NOP, NOP, ADD_X3);
    checkOutput("raw_memwb_out1", 32'(out1), 32'(RAW_EXP));
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, SUB_X3X1, ADD_X3, NOP, NOP);
    checkOutput("raw_idex_out3", 32'(out3), 32'(RAW_EXP));
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, NOP, NOP, NOP, NOP);
    checkOutput("raw_no_lu_out3", 32'(out3), 32'(NONE));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter XLEN, default 32, instruction width.
REQ-002 Parameter LOAD_LAT, default 1, range 1..7, number of bubble cycles inserted per load-use hazard.
REQ-003 Parameter CNTW, default 32, width of the stall performance counter.
REQ-004 clk  input  1  sole clock; all state updates on posedge clk.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 taken_branch  input  1  branch/jump in EX resolved taken this cycle.
REQ-007 mem_busy  input  1  data memory not ready; freeze whole pipeline.
REQ-008 if_id_instr, id_ex_instr, ex_mem_instr, mem_wb_instr  input  XLEN each  instruction held in ID, EX, MEM and WB respectively.
REQ-009 stall_if, stall_id, stall_ex, stall_mem  output  1 each  hold the corresponding stage register.
REQ-010 flush_id, flush_ex  output  1 each  replace the ID / EX stage contents with a bubble.
REQ-011 stall_cycles  output  CNTW  saturating count of cycles with stall_if=1.

Function
REQ-012 Source/destination decode SHALL use opcode bits [6:0]: rs1 is read by OP, OP-IMM, LOAD, STORE, BRANCH and JALR; rs2 is read by OP, STORE and BRANCH; rd is written by OP, OP-IMM, LOAD, LUI, AUIPC, JAL and JALR.
REQ-013 A register match on x0 SHALL never create a hazard, and unused rs fields SHALL be ignored.
REQ-014 Load-use hazard: id_ex_instr is LOAD, rd != 0, and rd equals an rs actually read by if_id_instr.
REQ-015 The FSM SHALL have two states, RUN and LU_STALL, plus a down-counter of width $clog2(LOAD_LAT+1).
REQ-016 In RUN, a load-use hazard SHALL assert stall_if, stall_id and flush_ex in the same cycle (combinational, zero latency).
REQ-017 On that hazard, if LOAD_LAT>1, the FSM SHALL enter LU_STALL with counter = LOAD_LAT-1; if LOAD_LAT=1, it SHALL remain in RUN.
REQ-018 In LU_STALL: stall_if, stall_id and flush_ex SHALL be asserted; the counter SHALL decrement each cycle; the FSM SHALL return to RUN when a decrement reaches 0. Total bubbles per hazard = LOAD_LAT.
REQ-019 On taken_branch=1 with mem_busy=0: flush_id=1 and flush_ex=1 for that cycle; stall_if and stall_id SHALL be 0; FSM -> RUN; counter cleared.
REQ-020 taken_branch SHALL take priority over load-use detection and over LU_STALL.
REQ-021 On mem_busy=1: stall_if, stall_id, stall_ex and stall_mem SHALL all be 1; flush_id and flush_ex SHALL be 0; FSM state and counter SHALL hold.
REQ-022 mem_busy SHALL have the highest priority. A taken_branch coincident with mem_busy is held by the frozen EX stage and SHALL be acted on in the first cycle with mem_busy=0.
REQ-023 stall_ex and stall_mem SHALL be asserted only by mem_busy.
REQ-024 stall_cycles SHALL increment by 1 each cycle stall_if=1 and SHALL saturate at all-ones (no wrap).

Reset
REQ-025 While rst=0 at posedge clk: FSM -> RUN, counter -> 0, stall_cycles -> 0.
REQ-026 While rst=0, all stall and flush outputs SHALL be driven 0 regardless of other inputs.
REQ-027 A reset asserted mid-LU_STALL SHALL abort the stall; the first cycle after rst returns to 1 starts in RUN.

Configuration
REQ-028 Macro HAZARD_FWD_EN selects the forwarding mode.
REQ-029 With HAZARD_FWD_EN defined, forwarding paths exist and only load-use hazards (REQ-014) SHALL stall.
REQ-030 With HAZARD_FWD_EN undefined, any RAW match between an rs read by if_id_instr and a nonzero rd written by id_ex_instr, ex_mem_instr or mem_wb_instr SHALL additionally assert stall_if, stall_id and flush_ex for every cycle the match persists. This condition does not enter LU_STALL, and branch/mem_busy priorities are unchanged.

Verification
REQ-031 Load-use, LOAD_LAT=1: id_ex = lw x5; if_id = add x6,x5,x7 -> exactly 1 cycle of stall_if=stall_id=flush_ex=1; stall_cycles increments by 1.
REQ-032 LOAD_LAT=3, same pair -> 3 consecutive stall cycles, then RUN; the x0 variant (lw x0; add x6,x0,x1) -> no stall.
REQ-033 taken_branch=1 in the 2nd cycle of a LOAD_LAT=3 stall -> flush_id=flush_ex=1 and stall_if=0 that cycle; no further stall.
REQ-034 mem_busy=1 for 4 cycles during LU_STALL with counter=1 -> all four stalls=1 for 4 cycles and counter holds; exactly 1 more bubble cycle after mem_busy falls.
REQ-035 rst=0 mid-stall -> outputs 0 immediately and stall_cycles=0; the counter at all-ones stays all-ones after further stalls.
REQ-036 HAZARD_FWD_EN undefined: ex_mem = add x3,..; if_id = sub x4,x3,x1 -> stall held until ex_mem no longer matches; with the macro defined -> no stall.
